// File: rtl/loader_pkg.sv
// Shared types and status codes for the boot-time program loader.
// PM_ADDR_WIDTH is the global program-memory byte-address width.
`ifndef PM_ADDR_WIDTH
`define PM_ADDR_WIDTH 16
`endif

package loader_pkg;

    typedef enum logic [2:0] {
        RECV_LEN,
        RECV_DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] LOADER_ACK = 8'hAA;
    localparam logic [7:0] LOADER_NAK = 8'hEE;

    function automatic logic is_terminal(input state_t s);
        return (s == DONE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, program-memory write and status-byte signals of the loader.
// master = loader side, slave = UART / program-memory side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = `PM_ADDR_WIDTH
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] pm_write_address;
    logic [31:0]           pm_write_data;
    logic                  pm_write_enable;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output pm_write_address, pm_write_data, pm_write_enable, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  pm_write_address, pm_write_data, pm_write_enable, tx_data, tx_valid
    );
endinterface

// File: rtl/byte_word_assembler.sv
// Packs bytes MSB-first into 32-bit words; word_complete flags the 4th byte,
// with the full word presented combinationally alongside it.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  count_q;
    logic [23:0] shift_q;

    assign word          = {shift_q, byte_data};
    assign word_complete = byte_valid && (count_q == 2'd3);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset_n) begin
            count_q <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            count_q <= count_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_data};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Length-prefixed program image loader feeding the program-memory write port.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH    = `PM_ADDR_WIDTH,
    parameter int MEM_SIZE_BYTE = 65536
) (
    input  logic              clk,
    input  logic              reset_n,
    program_loader_if.master  bus,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int          WIDX_W    = ADDR_WIDTH - 2;
    localparam int          CNT_W     = ADDR_WIDTH - 1;
    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE_BYTE / 4);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t state_q, state_d;

    logic              asm_valid;
    logic              word_complete;
    logic [31:0]       asm_word;
    logic              write_word;
    logic              load_len;
    logic              enter_term;

    logic [WIDX_W-1:0]     word_idx_q;
    logic [CNT_W-1:0]      remaining_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  we_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  busy_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    // Length and data bytes share the assembler; bytes are dropped elsewhere.
    assign asm_valid = bus.rx_valid && ((state_q == RECV_LEN) || (state_q == RECV_DATA));

    byte_word_assembler u_assembler (
        .clk           (clk),
        .reset_n       (reset_n),
        .byte_valid    (asm_valid),
        .byte_data     (bus.rx_data),
        .word          (asm_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RECV_LEN;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        state_d    = state_q;
        write_word = 1'b0;
        load_len   = 1'b0;
        case (state_q)
            RECV_LEN: begin
                if (word_complete) begin
                    if (asm_word > MEM_WORDS)  state_d = ERROR;
                    else if (asm_word == '0)   state_d = END_STATE;
                    else begin
                        state_d  = RECV_DATA;
                        load_len = 1'b1;
                    end
                end
            end
            RECV_DATA: begin
                if (word_complete) begin
                    write_word = 1'b1;
                    if (remaining_q == CNT_W'(1)) state_d = END_STATE;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: state_d = state_q;
            default:     state_d = ERROR;
        endcase
    end

    assign enter_term = is_terminal(state_d) && !is_terminal(state_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_idx_q  <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            we_q <= write_word;
            if (load_len) remaining_q <= asm_word[CNT_W-1:0];
            if (write_word) begin
                addr_q      <= {word_idx_q, 2'b00};
                data_q      <= asm_word;
                word_idx_q  <= word_idx_q + WIDX_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end
            busy_q <= !is_terminal(state_d) && (busy_q || bus.rx_valid);
            if (enter_term) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= (state_d == DONE) ? LOADER_ACK : LOADER_NAK;
            end else if (tx_valid_q && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (asm_valid) csum_q <= csum_q ^ bus.rx_data;
`endif
        end
    end

    assign bus.pm_write_address = addr_q;
    assign bus.pm_write_data    = data_q;
    assign bus.pm_write_enable  = we_q;
    assign bus.tx_data          = tx_data_q;
    assign bus.tx_valid         = tx_valid_q;
    assign busy                 = busy_q;
    assign load_done            = (state_q == DONE);
    assign load_error           = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames checked against a byte-level model of the
// frame format, expected memory writes and status byte.
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW        = 16;
    localparam int MEM_SIZE  = 65536;
    localparam int MEM_WORDS = MEM_SIZE / 4;

    logic clk = 1'b0;
    logic reset_n;
    logic busy, load_done, load_error;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .MEM_SIZE_BYTE(MEM_SIZE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t writes[$];

    // One entry per cycle the write strobe is high.
    always @(negedge clk) begin
        if (bus.pm_write_enable === 1'b1) writes.push_back('{bus.pm_write_address, bus.pm_write_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        writes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int unsigned n, input logic [31:0] words[$],
                             input logic [7:0] csum_err, input int max_gap, input int hold);
        logic [7:0]  bytes[$];
        logic [7:0]  csum;
        logic [31:0] nl;
        logic [31:0] w;
        logic [7:0]  exp_status;
        bit          over;
        bit          ok;
        bit          stable;
        int          exp_writes;

        nl   = n;
        over = (n > MEM_WORDS);
        for (int i = 3; i >= 0; i--) bytes.push_back(nl[i*8 +: 8]);
        if (!over) begin
            foreach (words[k]) begin
                w = words[k];
                for (int i = 3; i >= 0; i--) bytes.push_back(w[i*8 +: 8]);
            end
        end
        csum = 8'h00;
        foreach (bytes[k]) csum ^= bytes[k];
        ok = !over;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (!over) begin
            bytes.push_back(csum ^ csum_err);
            ok = (csum_err == 8'h00);
        end
`endif
        exp_status = ok ? LOADER_ACK : LOADER_NAK;
        exp_writes = over ? 0 : words.size();

        foreach (bytes[k]) begin
            send_byte(bytes[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (k == 0) check({tag, " busy_first"}, busy, 1);
        end

        check({tag, " load_done"},  load_done,  ok);
        check({tag, " load_error"}, load_error, !ok);
        check({tag, " busy_end"},   busy,       0);
        check({tag, " tx_valid"},   bus.tx_valid, 1);
        check({tag, " tx_data"},    bus.tx_data,  exp_status);

        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!(bus.tx_valid === 1'b1 && bus.tx_data === exp_status)) stable = 1'b0;
        end
        check({tag, " tx_hold"}, stable, 1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check({tag, " tx_drop"}, bus.tx_valid, 0);

        // Bytes after the frame must be ignored.
        for (int i = 0; i < 3; i++) send_byte(8'h5A, 0);
        @(negedge clk);
        check({tag, " write_count"}, writes.size(), exp_writes);
        for (int k = 0; k < exp_writes && k < writes.size(); k++) begin
            check({tag, $sformatf(" addr%0d", k)}, writes[k].addr, 32'(k * 4));
            check({tag, $sformatf(" data%0d", k)}, writes[k].data, words[k]);
        end
        check({tag, " tx_requeue"}, bus.tx_valid, 0);
        check({tag, " sticky"}, {load_done, load_error}, {ok, !ok});
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] none[$];
        logic [7:0]  cerr;

        do_reset();
        check("rst addr",       bus.pm_write_address, 0);
        check("rst data",       bus.pm_write_data,    0);
        check("rst we",         bus.pm_write_enable,  0);
        check("rst tx_data",    bus.tx_data,          0);
        check("rst tx_valid",   bus.tx_valid,         0);
        check("rst busy",       busy,                 0);
        check("rst load_done",  load_done,            0);
        check("rst load_error", load_error,           0);

        q.delete();
        q.push_back(32'h12345678);
        q.push_back(32'hDEADBEEF);
        run_frame("n2", 2, q, 8'h00, 0, 10);
        do_reset();

        run_frame("n0", 0, none, 8'h00, 0, 2);
        do_reset();

        run_frame("ovf", MEM_WORDS + 1, none, 8'h00, 0, 1);
        do_reset();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        q.delete();
        q.push_back(32'h01020304);
        run_frame("csum_bad", 1, q, 8'h03, 0, 1);
        do_reset();
`endif

        // Abort in the middle of word 0, then load a fresh image.
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        do_reset();
        check("abort busy", busy, 0);
        q.delete();
        q.push_back(32'hCAFEF00D);
        run_frame("after_rst", 1, q, 8'h00, 0, 1);
        do_reset();

        for (int f = 0; f < 10; f++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) q.push_back($urandom);
            cerr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame($sformatf("rand%0d", f), q.size(), q, cerr, 2, $urandom_range(0, 4));
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
